mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter NCH, default 2: number of requester channels, legal range 1..8.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width, a multiple of 8; strobe width SW = DW/8.
REQ-004 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  in  NCH  per-channel request valid.
REQ-007 SHALL have port req_ready  out  NCH  per-channel request accept.
REQ-008 SHALL have port req_addr  in  NCH*AW  packed addresses; channel i occupies bits [i*AW +: AW].
REQ-009 SHALL have port req_wen  in  NCH  1 = write, 0 = read.
REQ-010 SHALL have port req_wdata  in  NCH*DW  packed write data.
REQ-011 SHALL have port req_wmask  in  NCH*SW  packed byte strobes.
REQ-012 SHALL have port rsp_valid  out  NCH  one-cycle response pulse to the owning channel.
REQ-013 SHALL have port rsp_rdata  out  DW  shared read data, valid when any rsp_valid bit is set.
REQ-014 SHALL have port mem_req_valid  out  1  downstream request valid.
REQ-015 SHALL have port mem_req_ready  in  1  downstream request accept.
REQ-016 SHALL have ports mem_addr out AW, mem_wen out 1, mem_wdata out DW, mem_wmask out SW, carrying the downstream request fields.
REQ-017 SHALL have ports mem_rsp_valid in 1 and mem_rsp_rdata in DW, carrying the downstream response.

Function
REQ-018 SHALL implement states IDLE, REQ, WAIT, RESP, with at most one transaction outstanding.
REQ-019 IDLE: if any req_valid is set, SHALL assert req_ready only for the granted channel g, latch addr, wen, wdata and wmask from g, and go to REQ; otherwise req_ready = 0.
REQ-020 req_ready SHALL be 0 in REQ, WAIT and RESP.
REQ-021 REQ: SHALL assert mem_req_valid and drive the latched fields; on mem_req_ready = 1, go to WAIT.
REQ-022 Latched fields SHALL stay stable while mem_req_valid = 1 and mem_req_ready = 0.
REQ-023 On reads, mem_wmask and mem_wdata SHALL be driven 0 regardless of the latched values.
REQ-024 WAIT: on mem_rsp_valid, SHALL register mem_rsp_rdata (forced to 0 for writes) and go to RESP.
REQ-025 mem_rsp_valid SHALL be ignored outside WAIT.
REQ-026 RESP: SHALL assert rsp_valid[g] for exactly one cycle and return to IDLE.
REQ-027 Latency SHALL be: acceptance edge at cycle 0, mem_req_valid in cycle 1, rsp_valid at the earliest in cycle 3 with zero-wait memory.
REQ-028 rsp_rdata SHALL hold its last value outside RESP.
REQ-029 Writes SHALL also produce a rsp_valid pulse (acknowledge).
REQ-030 A channel dropping req_valid before acceptance SHALL simply not be granted; no error is raised.
REQ-031 With NCH = 1, arbitration SHALL degenerate to a direct grant of channel 0.

Reset
REQ-032 When rst = 0 at a rising edge: state SHALL go to IDLE, req_ready and rsp_valid to 0, mem_req_valid to 0, latched fields and rsp_rdata to 0, and the priority pointer to 0.
REQ-033 A reset arriving in REQ, WAIT or RESP SHALL abort the transaction with no rsp_valid pulse; a late mem_rsp_valid after reset SHALL be ignored.

Configuration
REQ-034 Macro MEM_ARB_RR_EN defined: SHALL arbitrate round-robin, searching from pointer ptr upward with wrap; after a grant to g, ptr SHALL become (g+1) mod NCH.
REQ-035 MEM_ARB_RR_EN undefined: SHALL use fixed priority, lowest index wins; the pointer logic is absent.

Verification
REQ-036 Single read: ch0 reads addr 0x80000000, memory returns 0x00100073 one cycle after handshake -> rsp_valid[0] one cycle, rsp_rdata = 0x00100073, total 3 cycles.
REQ-037 Write: ch1 wen = 1, addr 0x80000010, wdata 0xDEADBEEF, wmask 0x3 -> mem_wmask = 0x3, rsp_valid[1] pulse, rsp_rdata = 0.
REQ-038 Contention, NCH = 2, both channels held valid for 4 transactions: with MEM_ARB_RR_EN the grant order SHALL be 0,1,0,1; without it, 0,0,0,0.
REQ-039 Back-pressure: mem_req_ready held 0 for 5 cycles -> mem_req_valid and all fields stable, and no req_ready asserted on any channel.
REQ-040 Reset mid-op: rst = 0 in WAIT, then mem_rsp_valid pulses -> no rsp_valid, state IDLE, next request served normally.
REQ-041 Stray response: mem_rsp_valid = 1 in IDLE with rdata 0x12345678 -> no rsp_valid, rsp_rdata unchanged.

Source files
------------

// File: rtl/mem_arb.sv
// Single-outstanding arbiter: NCH requesters share one memory request/response port.
// Accept -> mem_req_valid next cycle -> rsp_valid >= 3 cycles later; define MEM_ARB_RR_EN for round-robin.
module mem_arb #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req_valid,
    output logic [NCH-1:0]        req_ready,
    input  logic [NCH*AW-1:0]     req_addr,
    input  logic [NCH-1:0]        req_wen,
    input  logic [NCH*DW-1:0]     req_wdata,
    input  logic [NCH*(DW/8)-1:0] req_wmask,
    output logic [NCH-1:0]        rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_wen,
    output logic [DW-1:0]         mem_wdata,
    output logic [DW/8-1:0]       mem_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DW-1:0]         mem_rsp_rdata
);
    localparam int SW = DW / 8;
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d, pick;
    logic [AW-1:0] addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wmask_q, wmask_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          any_vld;

    assign any_vld = |req_valid;

`ifdef MEM_ARB_RR_EN
    logic [GW-1:0] ptr_q, ptr_d;

    // Lowest requester overall covers the wrap case; any requester at/above ptr overrides it.
    always_comb begin
        pick = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (req_valid[c]) pick = GW'(c);
        end
        for (int c = NCH - 1; c >= 0; c--) begin
            if (req_valid[c] && (GW'(c) >= ptr_q)) pick = GW'(c);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && any_vld) begin
            ptr_d = (pick == GW'(NCH - 1)) ? '0 : pick + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end
`else
    always_comb begin
        pick = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (req_valid[c]) pick = GW'(c);
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        rdata_d       = rdata_q;
        req_ready     = '0;
        mem_req_valid = 1'b0;
        rsp_valid     = '0;
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    req_ready = NCH'(1) << pick;
                    gnt_d     = pick;
                    for (int c = 0; c < NCH; c++) begin
                        if (GW'(c) == pick) begin
                            addr_d  = req_addr[c*AW +: AW];
                            wen_d   = req_wen[c];
                            wdata_d = req_wdata[c*DW +: DW];
                            wmask_d = req_wmask[c*SW +: SW];
                        end
                    end
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = wen_q ? '0 : mem_rsp_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = NCH'(1) << gnt_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
        end
    end

    // Reads never expose stale write payload downstream.
    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wen_q ? wdata_q : '0;
    assign mem_wmask = wen_q ? wmask_q : '0;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed vector table, contention/reset/stray sequences, then random traffic
// checked against a transaction-level arbitration model.
module tb_mem_arb;
    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       req_valid;
    logic [NCH-1:0]       req_ready;
    logic [NCH*AW-1:0]    req_addr;
    logic [NCH-1:0]       req_wen;
    logic [NCH*DW-1:0]    req_wdata;
    logic [NCH*SW-1:0]    req_wmask;
    logic [NCH-1:0]       rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [AW-1:0]        mem_addr;
    logic                 mem_wen;
    logic [DW-1:0]        mem_wdata;
    logic [SW-1:0]        mem_wmask;
    logic                 mem_rsp_valid;
    logic [DW-1:0]        mem_rsp_rdata;

    logic [AW-1:0] ch_addr  [NCH];
    logic          ch_wen   [NCH];
    logic [DW-1:0] ch_wdata [NCH];
    logic [SW-1:0] ch_wmask [NCH];

    int checks = 0;
    int errors = 0;
    int mptr   = 0;
    logic [DW-1:0] last_rd;

    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_wen   = '0;
        req_wdata = '0;
        req_wmask = '0;
        for (int c = 0; c < NCH; c++) begin
            req_addr[c*AW +: AW]  = ch_addr[c];
            req_wen[c]            = ch_wen[c];
            req_wdata[c*DW +: DW] = ch_wdata[c];
            req_wmask[c*SW +: SW] = ch_wmask[c];
        end
    end

    mem_arb #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    typedef struct {
        int            ch;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wmask;
        logic [DW-1:0] mem_rd;
        int            rdy_dly;
        int            rsp_dly;
        logic [DW-1:0] exp_wd;
        logic [SW-1:0] exp_wm;
        logic [DW-1:0] exp_rd;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Arbitration model: scan channels in priority order starting from the model pointer.
    function automatic int model_grant(input logic [NCH-1:0] m);
        logic [NCH-1:0] sh;
        int idx;
        for (int k = 0; k < NCH; k++) begin
`ifdef MEM_ARB_RR_EN
            idx = (mptr + k) % NCH;
`else
            idx = k;
`endif
            sh = m >> idx;
            if (sh[0]) return idx;
        end
        return 0;
    endfunction

    function automatic void model_advance(input int g);
`ifdef MEM_ARB_RR_EN
        mptr = (g + 1) % NCH;
`else
        mptr = g;
        mptr = 0;
`endif
    endfunction

    task automatic txn(input logic [NCH-1:0] vmask, input int g, input logic [DW-1:0] mrd,
                       input int rdy_dly, input int rsp_dly, input logic [DW-1:0] exp_wd,
                       input logic [SW-1:0] exp_wm, input logic [DW-1:0] exp_rd, input string nm);
        logic [NCH-1:0] oh;
        oh = NCH'(1) << g;
        @(negedge clk);
        req_valid = vmask; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        chk({nm, " grant"}, 64'(req_ready), 64'(oh));
        chk({nm, " idle_mreq"}, 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        req_valid = '0; mem_req_ready = (rdy_dly == 0);
        #1;
        chk({nm, " mreq_vld"}, 64'(mem_req_valid), 64'd1);
        chk({nm, " addr"}, 64'(mem_addr), 64'(ch_addr[g]));
        chk({nm, " wen"}, 64'(mem_wen), 64'(ch_wen[g]));
        chk({nm, " wdata"}, 64'(mem_wdata), 64'(exp_wd));
        chk({nm, " wmask"}, 64'(mem_wmask), 64'(exp_wm));
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            req_valid = '1; mem_req_ready = (i == rdy_dly - 1);
            mem_rsp_valid = 1'b1; mem_rsp_rdata = $urandom;
            #1;
            chk({nm, " stall_vld"}, 64'(mem_req_valid), 64'd1);
            chk({nm, " stall_addr"}, 64'(mem_addr), 64'(ch_addr[g]));
            chk({nm, " stall_wdata"}, 64'(mem_wdata), 64'(exp_wd));
            chk({nm, " stall_wmask"}, 64'(mem_wmask), 64'(exp_wm));
            chk({nm, " stall_rdy"}, 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        req_valid = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = (rsp_dly == 0); mem_rsp_rdata = (rsp_dly == 0) ? mrd : DW'($urandom);
        #1;
        chk({nm, " wait_mreq"}, 64'(mem_req_valid), 64'd0);
        chk({nm, " wait_rsp"}, 64'(rsp_valid), 64'd0);
        for (int i = 0; i < rsp_dly; i++) begin
            @(negedge clk);
            mem_rsp_valid = (i == rsp_dly - 1);
            mem_rsp_rdata = (i == rsp_dly - 1) ? mrd : DW'($urandom);
            #1;
            chk({nm, " wait_rsp"}, 64'(rsp_valid), 64'd0);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = $urandom;
        #1;
        chk({nm, " rsp_vld"}, 64'(rsp_valid), 64'(oh));
        chk({nm, " rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        chk({nm, " rsp_pulse"}, 64'(rsp_valid), 64'd0);
        chk({nm, " rsp_hold"}, 64'(rsp_rdata), 64'(exp_rd));
        last_rd = exp_rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req_valid = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        chk("rst rsp_rdata", 64'(rsp_rdata), 64'd0);
        rst = 1'b1;
        mptr = 0;
        last_rd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [4];
        int   ord [4];
        int   g;
        logic [NCH-1:0] vm;
        logic [DW-1:0]  mrd;

        vt[0] = '{0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0010_0073, 0, 0,
                  32'h0, 4'h0, 32'h0010_0073};
        vt[1] = '{1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'h3, 32'hCAFE_F00D, 0, 0,
                  32'hDEAD_BEEF, 4'h3, 32'h0};
        vt[2] = '{0, 1'b1, 32'h0000_0004, 32'h0123_4567, 4'hC, 32'h0000_0055, 5, 2,
                  32'h0123_4567, 4'hC, 32'h0};
        vt[3] = '{1, 1'b0, 32'hFFFF_FFFC, 32'hAAAA_5555, 4'hF, 32'hFFFF_FFFF, 1, 3,
                  32'h0, 4'h0, 32'hFFFF_FFFF};
`ifdef MEM_ARB_RR_EN
        ord = '{0, 1, 0, 1};
`else
        ord = '{0, 0, 0, 0};
`endif

        rst = 1'b0; req_valid = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0; last_rd = '0;
        for (int c = 0; c < NCH; c++) begin
            ch_addr[c] = '0; ch_wen[c] = 1'b0; ch_wdata[c] = '0; ch_wmask[c] = '0;
        end
        do_reset();

        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < NCH; c++) begin
                ch_addr[c] = $urandom; ch_wen[c] = 1'($urandom); ch_wdata[c] = $urandom;
                ch_wmask[c] = SW'($urandom);
            end
            ch_addr[vt[i].ch] = vt[i].addr; ch_wen[vt[i].ch] = vt[i].wen;
            ch_wdata[vt[i].ch] = vt[i].wdata; ch_wmask[vt[i].ch] = vt[i].wmask;
            txn(NCH'(1) << vt[i].ch, vt[i].ch, vt[i].mem_rd, vt[i].rdy_dly, vt[i].rsp_dly,
                vt[i].exp_wd, vt[i].exp_wm, vt[i].exp_rd, $sformatf("vec%0d", i));
            model_advance(vt[i].ch);
        end

        // Stray response while idle must be dropped.
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1234_5678;
        #1;
        chk("stray rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        chk("stray rsp_valid2", 64'(rsp_valid), 64'd0);
        chk("stray rsp_rdata", 64'(rsp_rdata), 64'(last_rd));
        chk("stray mem_req_valid", 64'(mem_req_valid), 64'd0);

        // Both channels held valid across four transactions.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < NCH; c++) begin
                ch_addr[c] = 32'h100 * (c + 1) + i; ch_wen[c] = 1'b0;
                ch_wdata[c] = $urandom; ch_wmask[c] = SW'($urandom);
            end
            mrd = $urandom;
            txn('1, ord[i], mrd, 0, 0, '0, '0, mrd, $sformatf("cont%0d", i));
            model_advance(ord[i]);
        end

        // Reset while waiting for the memory response.
        do_reset();
        ch_addr[1] = 32'h55AA_0000; ch_wen[1] = 1'b0;
        @(negedge clk);
        req_valid = 2'b10; mem_req_ready = 1'b1;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        chk("rstmid in_wait", 64'(mem_req_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0BAD_F00D;
        #1;
        chk("rstmid rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstmid mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        chk("rstmid late_rsp", 64'(rsp_valid), 64'd0);
        chk("rstmid rsp_rdata", 64'(rsp_rdata), 64'd0);
        mptr = 0;
        ch_addr[0] = 32'h8000_0000; ch_wen[0] = 1'b0;
        txn(2'b01, 0, 32'h0010_0073, 0, 0, '0, '0, 32'h0010_0073, "rstmid next");
        model_advance(0);

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < NCH; c++) begin
                ch_addr[c] = $urandom; ch_wen[c] = 1'($urandom); ch_wdata[c] = $urandom;
                ch_wmask[c] = SW'($urandom);
            end
            vm  = NCH'($urandom_range(1, (1 << NCH) - 1));
            g   = model_grant(vm);
            mrd = $urandom;
            txn(vm, g, mrd, $urandom_range(0, 3), $urandom_range(0, 3),
                ch_wen[g] ? ch_wdata[g] : '0, ch_wen[g] ? ch_wmask[g] : '0,
                ch_wen[g] ? '0 : mrd, $sformatf("rnd%0d", i));
            model_advance(g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
